// File: rtl/apb_cnt_pkg.sv
// Shared constants for the APB counter bank.
// Register offsets, CTRL/STATUS bit positions, bus FSM states.
package apb_cnt_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_COUNT  = 4'h4;
  localparam logic [3:0] OFF_MAX    = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_CLR     = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_IE      = 3;
  localparam int unsigned STATUS_WRAP  = 0;

  localparam int unsigned MAX_RST = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/apb_cnt_channel.sv
// One counter channel: COUNT, MAX, CTRL and sticky WRAP.
// CTRL.IE is a real register only when APB_CNT_IRQ_EN is defined.
module apb_cnt_channel
  import apb_cnt_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_ctrl_i,
  input  logic        wr_count_i,
  input  logic        wr_max_i,
  input  logic        wr_status_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rsel_i,
  output logic [31:0] rdata_o,
  output logic        wrap_o,
  output logic        ie_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] wval;
  logic en_q, en_d;
  logic os_q, os_d;
  logic wrap_q, wrap_d;
  logic wrap_set, wrap_clr;
  logic ie;
  logic unused_wdata;

  assign wval = wdata_i[CNT_W-1:0];
  assign unused_wdata = ^wdata_i;

  // Next state: CLR beats COUNT write beats increment.
  always_comb begin
    count_d  = count_q;
    max_d    = max_q;
    en_d     = en_q;
    os_d     = os_q;
    wrap_set = 1'b0;
    wrap_clr = 1'b0;
    if (wr_ctrl_i && wdata_i[CTRL_CLR]) begin
      count_d = '0;
    end else if (wr_count_i) begin
      count_d = wval;
    end else if (en_q) begin
      if (count_q < max_q) begin
        count_d = count_q + CNT_W'(1);
      end else if (os_q && count_q == max_q) begin
        en_d     = 1'b0;
        wrap_set = 1'b1;
      end else begin
        count_d  = '0;
        wrap_set = 1'b1;
      end
    end
    if (wr_max_i) begin
      max_d = wval;
    end
    if (wr_ctrl_i) begin
      en_d = wdata_i[CTRL_EN];
      os_d = wdata_i[CTRL_ONESHOT];
    end
    wrap_clr = wr_status_i & wdata_i[STATUS_WRAP];
    wrap_d   = (wrap_q & ~wrap_clr) | wrap_set;
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      max_q   <= CNT_W'(MAX_RST);
      en_q    <= 1'b0;
      os_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      en_q    <= en_d;
      os_q    <= os_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef APB_CNT_IRQ_EN
  logic ie_q;

  // Interrupt enable bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie_q <= 1'b0;
    end else if (wr_ctrl_i) begin
      ie_q <= wdata_i[CTRL_IE];
    end
  end

  assign ie = ie_q;
`else
  assign ie = 1'b0;
`endif

  // Register read mux, zero-extended.
  always_comb begin
    rdata_o = '0;
    unique case (rsel_i)
      OFF_CTRL[3:2]: begin
        rdata_o[CTRL_EN]      = en_q;
        rdata_o[CTRL_ONESHOT] = os_q;
        rdata_o[CTRL_IE]      = ie;
      end
      OFF_COUNT[3:2]: rdata_o = 32'(count_q);
      OFF_MAX[3:2]:   rdata_o = 32'(max_q);
      default:        rdata_o[STATUS_WRAP] = wrap_q;
    endcase
  end

  assign wrap_o = wrap_q;
  assign ie_o   = ie;

endmodule

// File: rtl/apb_counter_bank.sv
// APB counter bank top: bus FSM, decode, read capture.
// Optional IRQ output enabled by defining APB_CNT_IRQ_EN.
module apb_counter_bank
  import apb_cnt_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PRWADDR,
  input  logic [31:0] PRWDATA,
  output logic [31:0] PRWDATA1,
  output logic        PREADY,
  output logic        PSLVERR
`ifdef APB_CNT_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  bus_state_e state_q, state_d;

  logic [27:0] ch_idx;
  logic [1:0]  rsel;
  logic        hit;
  logic        commit;
  logic        wr_ok;
  logic [31:0] rd_mux;
  logic [31:0] prdata_q;
  logic        pslverr_q;
  logic [31:0] ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] ch_wrap;
  logic [NUM_CH-1:0] ch_ie;
  logic unused_addr;

  assign ch_idx = PRWADDR[31:4];
  assign rsel   = PRWADDR[3:2];
  assign hit    = ch_idx < 28'(NUM_CH);
  assign commit = (state_q == ST_WAIT) && PSEL;
  assign wr_ok  = commit && PWRITE && hit;
  assign unused_addr = ^PRWADDR[1:0];

  // Bus FSM next state: one wait state, abort on PSEL drop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (PSEL && PENABLE) state_d = ST_WAIT;
      ST_WAIT: state_d = PSEL ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_ok && (ch_idx == 28'(c));

    apb_cnt_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i      (PCLK),
      .rst_ni     (PRESETn),
      .wr_ctrl_i  (sel && rsel == OFF_CTRL[3:2]),
      .wr_count_i (sel && rsel == OFF_COUNT[3:2]),
      .wr_max_i   (sel && rsel == OFF_MAX[3:2]),
      .wr_status_i(sel && rsel == OFF_STATUS[3:2]),
      .wdata_i    (PRWDATA),
      .rsel_i     (rsel),
      .rdata_o    (ch_rdata[c]),
      .wrap_o     (ch_wrap[c]),
      .ie_o       (ch_ie[c])
    );
  end

  // Select the addressed channel's read data.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 28'(c)) rd_mux = ch_rdata[c];
    end
  end

  // Capture response on entry to DONE; unmapped returns zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pslverr_q <= commit && !hit;
      if (commit && (!PWRITE || !hit)) begin
        prdata_q <= (hit && !PWRITE) ? rd_mux : '0;
      end
    end
  end

  assign PRWDATA1 = prdata_q;
  assign PSLVERR  = pslverr_q;
  assign PREADY   = (state_q == ST_DONE);

`ifdef APB_CNT_IRQ_EN
  logic irq_q;

  // Registered OR of enabled wrap flags.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(ch_wrap & ch_ie);
    end
  end

  assign IRQ = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{ch_wrap, ch_ie};
`endif

endmodule

// File: tb/tb_apb_counter_bank.sv
// Directed bench for apb_counter_bank.
// Two DUTs: default (CNT_W=16) and CNT_W=8.
module tb_apb_counter_bank;

  logic        PCLK;
  logic        PRESETn;
  logic        PENABLE;
  logic        PWRITE;
  logic        psel0;
  logic        psel8;
  logic [31:0] PRWADDR;
  logic [31:0] PRWDATA;
  logic [31:0] prd0, prd8;
  logic        rdy0, rdy8;
  logic        err0, err8;
`ifdef APB_CNT_IRQ_EN
  logic        irq0, irq8;
`endif

  int passed;
  int total;
  int last_wait;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_counter_bank u_dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (psel0),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PRWADDR (PRWADDR),
    .PRWDATA (PRWDATA),
    .PRWDATA1(prd0),
    .PREADY  (rdy0),
    .PSLVERR (err0)
`ifdef APB_CNT_IRQ_EN
    ,
    .IRQ     (irq0)
`endif
  );

  apb_counter_bank #(
    .NUM_CH(4),
    .CNT_W (8)
  ) u_dut8 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (psel8),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PRWADDR (PRWADDR),
    .PRWDATA (PRWDATA),
    .PRWDATA1(prd8),
    .PREADY  (rdy8),
    .PSLVERR (err8)
`ifdef APB_CNT_IRQ_EN
    ,
    .IRQ     (irq8)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h",
                tag, got, exp);
  endtask

  function automatic logic rdy(input bit d);
    return d ? rdy8 : rdy0;
  endfunction

  // One APB transfer; expectation queued at access phase.
  task automatic apb(input bit d, input bit wr,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [31:0] exp_d,
                     input logic exp_e,
                     input string tag);
    exp_t e;
    int n;
    @(posedge PCLK); #1;
    psel0   = !d;
    psel8   = d;
    PWRITE  = wr;
    PRWADDR = addr;
    PRWDATA = wdata;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    e.tag = tag;
    e.data = exp_d;
    e.err = exp_e;
    e.chk_data = !wr || exp_e;
    sb.push_back(e);
    n = 0;
    forever begin
      @(negedge PCLK);
      if (rdy(d) || n > 8) break;
      n++;
    end
    last_wait = n;
    e = sb.pop_front();
    if (!rdy(d)) begin
      check({e.tag, "_timeout"}, 32'(rdy(d)), 32'd1);
    end else begin
      if (e.chk_data)
        check(e.tag, d ? prd8 : prd0, e.data);
      check({e.tag, "_err"},
            32'(d ? err8 : err0), 32'(e.err));
    end
    @(posedge PCLK); #1;
    psel0   = 1'b0;
    psel8   = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] seq [8];
    passed    = 0;
    total     = 0;
    last_wait = 0;
    PRESETn   = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    psel0     = 1'b0;
    psel8     = 1'b0;
    PRWADDR   = '0;
    PRWDATA   = '0;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", 32'(rdy0), 32'd0);
    check("rst_pslverr", 32'(err0), 32'd0);
    check("rst_prdata", prd0, 32'd0);
    check("rst_prdata8", prd8, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Reset values and latency
    apb(0, 0, 32'h08, 0, 32'hF, 0, "ch0_max_rst");
    check("ch0_latency", 32'(last_wait), 32'd2);
    apb(0, 0, 32'h04, 0, 32'h0, 0, "ch0_count_rst");
    apb(0, 0, 32'h00, 0, 32'h0, 0, "ch0_ctrl_rst");
    apb(0, 0, 32'h0C, 0, 32'h0, 0, "ch0_status_rst");
    apb(0, 0, 32'h0B, 0, 32'hF, 0, "ch0_max_lowbits");

    // ch1 free-running with MAX=3
    apb(0, 1, 32'h18, 32'h3, 0, 0, "ch1_wr_max");
    apb(0, 1, 32'h10, 32'h1, 0, 0, "ch1_wr_ctrl");
    seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      check($sformatf("ch1_seq%0d", i),
            32'(u_dut.g_ch[1].u_ch.count_q), seq[i]);
      if (i == 2)
        check("ch1_wrap_pre",
              32'(u_dut.g_ch[1].u_ch.wrap_q), 32'd0);
      if (i == 3)
        check("ch1_wrap_set",
              32'(u_dut.g_ch[1].u_ch.wrap_q), 32'd1);
    end
    apb(0, 1, 32'h10, 32'h0, 0, 0, "ch1_stop");
    apb(0, 0, 32'h1C, 0, 32'h1, 0, "ch1_status_1");
    apb(0, 1, 32'h1C, 32'h1, 0, 0, "ch1_w1c");
    apb(0, 0, 32'h1C, 0, 32'h0, 0, "ch1_status_0");

    // ch2 one-shot
    apb(0, 1, 32'h28, 32'h5, 0, 0, "ch2_wr_max");
    apb(0, 1, 32'h20, 32'h5, 0, 0, "ch2_wr_ctrl");
    repeat (12) @(posedge PCLK);
    apb(0, 0, 32'h24, 0, 32'h5, 0, "ch2_count_hold");
    apb(0, 0, 32'h20, 0, 32'h4, 0, "ch2_ctrl_en_clr");
    apb(0, 0, 32'h2C, 0, 32'h1, 0, "ch2_wrap");
    apb(0, 1, 32'h20, 32'h2, 0, 0, "ch2_clr");
    apb(0, 0, 32'h24, 0, 32'h0, 0, "ch2_count_clr");
    apb(0, 0, 32'h20, 0, 32'h0, 0, "ch2_ctrl_clr_rd");

    // 8-bit counter instance
    apb(1, 0, 32'h08, 0, 32'hF, 0, "w8_max_rst");
    apb(1, 1, 32'h04, 32'h1FF, 0, 0, "w8_wr_count");
    apb(1, 0, 32'h04, 0, 32'hFF, 0, "w8_count_trunc");
    apb(1, 1, 32'h08, 32'hFF, 0, 0, "w8_wr_max");
    apb(1, 1, 32'h00, 32'h1, 0, 0, "w8_wr_ctrl");
    @(negedge PCLK);
    check("w8_wrap_cnt",
          32'(u_dut8.g_ch[0].u_ch.count_q), 32'h0);
    check("w8_wrap_flag",
          32'(u_dut8.g_ch[0].u_ch.wrap_q), 32'h1);
    apb(1, 1, 32'h00, 32'h0, 0, 0, "w8_stop");
    apb(1, 0, 32'h0C, 0, 32'h1, 0, "w8_status");

    // Unmapped addresses
    apb(0, 0, 32'hF0, 0, 32'h0, 1, "unmap_rd");
    apb(0, 1, 32'hF0, 32'h3, 32'h0, 1, "unmap_wr");
    apb(0, 1, 32'h48, 32'h7, 32'h0, 1, "unmap_ch4_wr");
    apb(0, 0, 32'h30, 0, 32'h0, 0, "ch3_ctrl_untouched");
    apb(0, 0, 32'h38, 0, 32'hF, 0, "ch3_max_untouched");
    apb(0, 0, 32'h08, 0, 32'hF, 0, "ch0_max_untouched");

    // Abort in WAIT: no response, no write
    @(posedge PCLK); #1;
    psel0 = 1'b1; PWRITE = 1'b1;
    PRWADDR = 32'h08; PRWDATA = 32'h7; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    psel0 = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check($sformatf("abort_pready%0d", i), 32'(rdy0), 32'd0);
    end
    apb(0, 0, 32'h08, 0, 32'hF, 0, "abort_max");

`ifdef APB_CNT_IRQ_EN
    apb(0, 1, 32'h08, 32'h2, 0, 0, "irq_wr_max");
    apb(0, 1, 32'h00, 32'h9, 0, 0, "irq_wr_ctrl");
    seq = '{0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check($sformatf("irq_seq%0d", i), 32'(irq0), seq[i]);
    end
    apb(0, 1, 32'h00, 32'h8, 0, 0, "irq_stop");
    apb(0, 1, 32'h0C, 32'h1, 0, 0, "irq_w1c");
    @(negedge PCLK);
    check("irq_cleared", 32'(irq0), 32'd0);
    apb(0, 0, 32'h00, 0, 32'h8, 0, "irq_ctrl_ie");
`else
    apb(0, 1, 32'h00, 32'h8, 0, 0, "ie_wr");
    apb(0, 0, 32'h00, 0, 32'h0, 0, "ie_reads0");
`endif

    // COUNT write path
    apb(0, 1, 32'h04, 32'h1234, 0, 0, "ch0_wr_count");
    apb(0, 0, 32'h04, 0, 32'h1234, 0, "ch0_count_rd");

    // Reset asserted while in DONE
    @(posedge PCLK); #1;
    psel0 = 1'b1; PWRITE = 1'b0;
    PRWADDR = 32'h18; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (rdy0 || n > 8) break;
      n++;
    end
    check("pre_rst_ready", 32'(rdy0), 32'd1);
    check("pre_rst_data", prd0, 32'h3);
    #1;
    PRESETn = 1'b0;
    #1;
    check("midrst_pready", 32'(rdy0), 32'd0);
    check("midrst_prdata", prd0, 32'h0);
    check("midrst_pslverr", 32'(err0), 32'd0);
    psel0 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb(0, 0, 32'h18, 0, 32'hF, 0, "post_rst_ch1_max");
    apb(0, 0, 32'h04, 0, 32'h0, 0, "post_rst_ch0_count");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_counter_bank.md
APB_COUNTER_BANK -- requirements
Module: apb_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent counter channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, counter width in bits (1..32).
REQ-003 SHALL have port PCLK, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port PRESETn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port PSEL, input, 1, peripheral select.
REQ-006 SHALL have port PENABLE, input, 1, access-phase enable.
REQ-007 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port PRWADDR, input, 32, byte address; bits [1:0] ignored.
REQ-009 SHALL have port PRWDATA, input, 32, write data.
REQ-010 SHALL have port PRWDATA1, output, 32, registered read data.
REQ-011 SHALL have port PREADY, output, 1, transfer complete.
REQ-012 SHALL have port PSLVERR, output, 1, error on unmapped address; valid only while PREADY=1.

Function
REQ-013 Register map per channel c at base c*0x10: +0x0 CTRL, +0x4 COUNT, +0x8 MAX, +0xC STATUS; any other address or channel >= NUM_CH is unmapped.
REQ-014 CTRL bits: [0] EN (RW), [1] CLR (write-1 pulse, reads 0), [2] ONESHOT (RW), [3] IE (see REQ-027); other bits read 0.
REQ-015 STATUS bit [0] WRAP: sticky, write-1-to-clear; other bits read 0.
REQ-016 Bus FSM states IDLE, WAIT, DONE: IDLE->WAIT on PSEL&PENABLE; WAIT->DONE next cycle; DONE->IDLE next cycle; PREADY=1 only in DONE (exactly one wait state).
REQ-017 Write takes effect on the DONE cycle edge; read data is captured into PRWDATA1 on entry to DONE and held until the next read.
REQ-018 Unmapped access: PSLVERR=1 in DONE, write discarded, PRWDATA1=0.
REQ-019 PSEL deasserted in WAIT aborts to IDLE, no register update, PREADY stays 0.
REQ-020 Counting: each cycle with EN=1, count<MAX -> count+1; count==MAX -> count=0 and WRAP=1; count>MAX -> count=0 and WRAP=1.
REQ-021 ONESHOT=1 at count==MAX: count holds MAX, EN cleared, WRAP=1.
REQ-022 Written COUNT/MAX values truncated to CNT_W; reads zero-extended to 32 bits.
REQ-023 Priority per channel: CLR > COUNT write > increment; hardware WRAP set beats simultaneous W1C.
REQ-024 MAX=0 with EN=1: count stays 0, WRAP set every cycle.

Reset
REQ-025 On PRESETn=0, immediately: COUNT=0, MAX=15, CTRL=0, WRAP=0, FSM=IDLE, PREADY=0, PSLVERR=0, PRWDATA1=0; reset mid-transfer discards the transfer.
REQ-026 First counter increment occurs no earlier than the second PCLK edge after PRESETn rises.

Configuration
REQ-027 With APB_CNT_IRQ_EN defined: CTRL[3] IE is RW and output port IRQ (1 bit, registered, reset 0) = OR over channels of (WRAP & IE), updated one cycle after WRAP/IE change.
REQ-028 Without APB_CNT_IRQ_EN: no IRQ port, CTRL[3] reads 0 and ignores writes.

Structure
REQ-029 Package apb_cnt_pkg SHALL hold register offsets, CTRL/STATUS bit indices, MAX reset value 15, and the bus FSM state enum.
REQ-030 Per-channel counter, MAX, CTRL and WRAP logic SHALL live in sub-module apb_cnt_channel, instantiated NUM_CH times via generate.

Verification
REQ-031 Reset, then read ch0 MAX -> PREADY high on 2nd access cycle, PRWDATA1=0x0000000F, PSLVERR=0.
REQ-032 Write ch1 MAX=3, CTRL=0x1 -> COUNT sequence 0,1,2,3,0; WRAP=1 at wrap; write STATUS=0x1 -> WRAP=0.
REQ-033 ch2 ONESHOT: MAX=5, CTRL=0x5 -> count stops at 5, CTRL reads 0x4, WRAP=1.
REQ-034 CNT_W=8: write COUNT=0x1FF -> reads 0xFF; running with MAX=0xFF wraps to 0x00.
REQ-035 Read address 0x0F0 (NUM_CH=4) -> PSLVERR=1, PRWDATA1=0; write there changes no register.
REQ-036 With APB_CNT_IRQ_EN: ch0 MAX=2, CTRL=0x9 -> IRQ=1 one cycle after WRAP; clear WRAP with EN=0 -> IRQ=0; assert PRESETn=0 mid-transfer -> PREADY=0 immediately.
